ar_pc_sequencer: RTL and testbench
==================================

# ar_pc_sequencer

Control sequencer for the basic computer's 12-bit address register (AR) and program counter (PC). It walks each instruction through the fixed fetch/decode/indirect cycle, hands off to the execute unit with a start/done handshake, and runs the interrupt cycle. It also merges execute-unit register requests so that AR and PC never see more than one of load/inc/clr in the same cycle.

## Interface
Parameters:
- none (widths fixed: 3-bit opcode, 3-bit bus select, 4-bit timing count)

Ports:
- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALTED and begin fetch
- ir_opcode  in  3  IR[14:12]; 7 = register/IO instruction
- ir_i  in  1  IR[15], indirect bit
- exec_done  in  1  execute unit finished current instruction
- exec_halt  in  1  qualifies exec_done: stop after this instruction
- ien, fgi, fgo  in  1 each  interrupt enable, input flag, output flag
- exec_ar_load, exec_ar_inc, exec_pc_load, exec_pc_inc  in  1 each  execute-unit register requests
- ar_load, ar_inc, ar_clr  out  1 each  AR commands
- pc_load, pc_inc, pc_clr  out  1 each  PC commands
- ir_load, tr_load, mem_read, mem_write  out  1 each  IR/TR load, memory strobes
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 5 IR, 6 TR, 7 memory
- ien_clr  out  1  clear IEN
- exec_start  out  1  one-cycle start pulse to execute unit
- running  out  1  high in every state except IDLE/HALTED
- seq_t  out  4  timing count, cycles since F0

## Operation
- States: IDLE, F0, F1, F2, F3, EXEC, INT0, INT1, INT2, HALTED.
- Outputs are decoded from the registered state (Moore). The exception is the EXEC pass-through, which is combinational from the exec_* inputs.
- F0: bus_sel=2, ar_load (AR<-PC). Next state F1.
- F1: mem_read, bus_sel=7, ir_load, pc_inc. Next state F2.
- F2: bus_sel=5, ar_load (AR<-IR[11:0]). Next state F3.
- F3, case ir_opcode!=7 and ir_i=1: mem_read, bus_sel=7, ar_load (AR<-M[AR]).
- F3, otherwise: no outputs.
- F3 always lasts exactly one cycle. Next state EXEC.
- EXEC:
  - exec_start=1 in the first EXEC cycle only.
  - AR/PC commands are the exec_* requests passed through, after conflict resolution.
- Conflict resolution, per register: load beats inc. The losing request is dropped.
- Leaving EXEC on exec_done, in priority order:
  - exec_halt=1 -> HALTED.
  - else ien & (fgi|fgo) -> INT0.
  - else -> F0.
- Requests present in the exec_done cycle are honoured in that cycle.
- INT0: ar_clr, bus_sel=2, tr_load (AR<-0, TR<-PC).
- INT1: bus_sel=6, mem_write, pc_clr (M[0]<-TR, PC<-0).
- INT2: pc_inc, ien_clr. Next state F0.
- IDLE/HALTED: all command outputs 0; start=1 -> F0.
- Invariant, checked by assertion: at most one of {ar_load, ar_inc, ar_clr} high per cycle, and likewise at most one of {pc_load, pc_inc, pc_clr}.

## Timing
- Reset (reset_n low, any state):
  - state=IDLE, seq_t=0, running=0.
  - Every output 0, including bus_sel=0.
  - Takes effect immediately, without waiting for a clock edge.
  - Aborts a fetch, EXEC or interrupt cycle mid-way; no partial commands persist.
- First rising edge with reset_n high and start=1: F0 in the following cycle.
- Fetch latency: fixed 4 cycles (F0-F3); exec_start asserted in cycle 5 counted from F0.
- exec_done sampled on every EXEC cycle, including the first: the minimum EXEC occupancy is 1 cycle.
- seq_t counting:
  - Cleared on entry to F0; increments every cycle while running.
  - Saturates at 15.
  - Held through INT0-INT2, then cleared at F0.
- Interrupt cycle: 3 cycles. First F0 after INT2 fetches from address 1.
- start while running is ignored.
- exec_* inputs outside EXEC are ignored.

## Test plan
- Reset then start; opcode=2, ir_i=0; exec_done in the 2nd EXEC cycle -> bus_sel sequence 2,7,5,0,0,0. pc_inc only in F1. exec_start exactly one cycle, with seq_t=4. Returns to F0.
- opcode=1, ir_i=1 -> in F3: mem_read=1, bus_sel=7, ar_load=1. Repeat with opcode=7, ir_i=1 -> F3 with all outputs 0.
- In EXEC, drive exec_pc_load=1 and exec_pc_inc=1 together -> only pc_load=1. Drive exec_ar_inc alone -> ar_inc=1.
- ien=1, fgi=1 at exec_done -> INT0: ar_clr, tr_load, bus_sel=2. INT1: mem_write, bus_sel=6, pc_clr. INT2: pc_inc, ien_clr. Then F0.
- exec_done with exec_halt=1 and ien=fgo=1 -> HALTED (halt wins). running=0; start then -> F0.
- Drop reset_n during F1 -> all outputs 0 immediately, before the next edge. State IDLE; running=0.

Source files
------------

// File: rtl/ar_pc_sequencer.sv
// Fetch/decode/indirect/interrupt sequencer for the basic computer's AR and PC.
// Execute-unit register requests are merged so at most one AR and one PC command is active per cycle.

module ar_pc_sequencer_chk (
    input logic       clk,
    input logic       reset_n,
    input logic [2:0] ar_cmd,
    input logic [2:0] pc_cmd
);

    // at most one command per register in any cycle
    always @(posedge clk) begin
        if (reset_n) begin
            a_ar_onehot: assert ($onehot0(ar_cmd));
            a_pc_onehot: assert ($onehot0(pc_cmd));
        end
    end

endmodule

module ar_pc_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] ir_opcode,
    input  logic       ir_i,
    input  logic       exec_done,
    input  logic       exec_halt,
    input  logic       ien,
    input  logic       fgi,
    input  logic       fgo,
    input  logic       exec_ar_load,
    input  logic       exec_ar_inc,
    input  logic       exec_pc_load,
    input  logic       exec_pc_inc,
    output logic       ar_load,
    output logic       ar_inc,
    output logic       ar_clr,
    output logic       pc_load,
    output logic       pc_inc,
    output logic       pc_clr,
    output logic       ir_load,
    output logic       tr_load,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] bus_sel,
    output logic       ien_clr,
    output logic       exec_start,
    output logic       running,
    output logic [3:0] seq_t
);

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F0     = 4'd1,
        S_F1     = 4'd2,
        S_F2     = 4'd3,
        S_F3     = 4'd4,
        S_EXEC   = 4'd5,
        S_INT0   = 4'd6,
        S_INT1   = 4'd7,
        S_INT2   = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       exec_first_r;
    logic [3:0] seq_t_r;

    // Load beats inc on the same register; returns {load, inc}.
    function automatic logic [1:0] resolve(input logic load_req, input logic inc_req);
        return {load_req, inc_req & ~load_req};
    endfunction

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // exec_start marks only the EXEC cycle that follows F3
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_first_r <= 1'b0;
        end else begin
            exec_first_r <= (state_r == S_F3);
        end
    end

    // timing count: cleared into F0, counts through fetch/exec, held elsewhere
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_t_r <= 4'd0;
        end else if (state_nxt_s == S_F0) begin
            seq_t_r <= 4'd0;
        end else if ((state_nxt_s inside {S_F1, S_F2, S_F3, S_EXEC}) && (seq_t_r != 4'd15)) begin
            seq_t_r <= seq_t_r + 4'd1;
        end else begin
            seq_t_r <= seq_t_r;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_nxt_s = S_F0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_F0:   state_nxt_s = S_F1;
            S_F1:   state_nxt_s = S_F2;
            S_F2:   state_nxt_s = S_F3;
            S_F3:   state_nxt_s = S_EXEC;
            S_EXEC: begin
                if (!exec_done) begin
                    state_nxt_s = S_EXEC;
                end else if (exec_halt) begin
                    state_nxt_s = S_HALTED;
                end else if (ien && (fgi || fgo)) begin
                    state_nxt_s = S_INT0;
                end else begin
                    state_nxt_s = S_F0;
                end
            end
            S_INT0: state_nxt_s = S_INT1;
            S_INT1: state_nxt_s = S_INT2;
            S_INT2: state_nxt_s = S_F0;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // command decode from state; EXEC passes merged execute-unit requests through
    always_comb begin
        ar_load    = 1'b0;
        ar_inc     = 1'b0;
        ar_clr     = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_clr     = 1'b0;
        ir_load    = 1'b0;
        tr_load    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        bus_sel    = BUS_NONE;
        ien_clr    = 1'b0;
        exec_start = 1'b0;
        running    = 1'b1;
        case (state_r)
            S_IDLE, S_HALTED: begin
                running = 1'b0;
            end
            S_F0: begin
                bus_sel = BUS_PC;
                ar_load = 1'b1;
            end
            S_F1: begin
                mem_read = 1'b1;
                bus_sel  = BUS_MEM;
                ir_load  = 1'b1;
                pc_inc   = 1'b1;
            end
            S_F2: begin
                bus_sel = BUS_IR;
                ar_load = 1'b1;
            end
            S_F3: begin
                if ((ir_opcode != 3'd7) && ir_i) begin
                    mem_read = 1'b1;
                    bus_sel  = BUS_MEM;
                    ar_load  = 1'b1;
                end else begin
                    mem_read = 1'b0;
                    bus_sel  = BUS_NONE;
                    ar_load  = 1'b0;
                end
            end
            S_EXEC: begin
                {ar_load, ar_inc} = resolve(exec_ar_load, exec_ar_inc);
                {pc_load, pc_inc} = resolve(exec_pc_load, exec_pc_inc);
                exec_start        = exec_first_r;
            end
            S_INT0: begin
                ar_clr  = 1'b1;
                bus_sel = BUS_PC;
                tr_load = 1'b1;
            end
            S_INT1: begin
                bus_sel   = BUS_TR;
                mem_write = 1'b1;
                pc_clr    = 1'b1;
            end
            S_INT2: begin
                pc_inc  = 1'b1;
                ien_clr = 1'b1;
            end
            default: begin
                running = 1'b0;
            end
        endcase
    end

    assign seq_t = seq_t_r;

    ar_pc_sequencer_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .ar_cmd  ({ar_load, ar_inc, ar_clr}),
        .pc_cmd  ({pc_load, pc_inc, pc_clr})
    );

endmodule

// File: tb/tb_ar_pc_sequencer.sv
// Self-checking bench for ar_pc_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-cycle expectation queue.

module tb_ar_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, start, ir_i, exec_done, exec_halt, ien, fgi, fgo;
    logic       exec_ar_load, exec_ar_inc, exec_pc_load, exec_pc_inc;
    logic [2:0] ir_opcode;
    logic       ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr;
    logic       ir_load, tr_load, mem_read, mem_write, ien_clr, exec_start, running;
    logic [2:0] bus_sel;
    logic [3:0] seq_t;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;

    logic [15:0] v_f0, v_f1, v_f2, v_f3i, v_run, v_int0, v_int1, v_int2;

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic        ind, dn, hl, ie, fi, fo, al, ai, pl, pi;
        logic [15:0] v;
        int          t;
    } ent_t;

    ent_t plan[$];

    always #5 clk = ~clk;

    assign obs = {ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr, ir_load, tr_load,
                  mem_read, mem_write, bus_sel, ien_clr, exec_start, running};

    ar_pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ir_opcode(ir_opcode), .ir_i(ir_i),
        .exec_done(exec_done), .exec_halt(exec_halt), .ien(ien), .fgi(fgi), .fgo(fgo),
        .exec_ar_load(exec_ar_load), .exec_ar_inc(exec_ar_inc),
        .exec_pc_load(exec_pc_load), .exec_pc_inc(exec_pc_inc),
        .ar_load(ar_load), .ar_inc(ar_inc), .ar_clr(ar_clr),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_clr(pc_clr),
        .ir_load(ir_load), .tr_load(tr_load), .mem_read(mem_read), .mem_write(mem_write),
        .bus_sel(bus_sel), .ien_clr(ien_clr), .exec_start(exec_start),
        .running(running), .seq_t(seq_t)
    );

    function automatic logic [15:0] ev(input logic al, ai, ac, pl, pi, pc, irl, trl, mr, mw,
                                       input logic [2:0] bs, input logic ic, es, run);
        return {al, ai, ac, pl, pi, pc, irl, trl, mr, mw, bs, ic, es, run};
    endfunction

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        start = 1'b0; ir_opcode = 3'd0; ir_i = 1'b0; exec_done = 1'b0; exec_halt = 1'b0;
        ien = 1'b0; fgi = 1'b0; fgo = 1'b0;
        exec_ar_load = 1'b0; exec_ar_inc = 1'b0; exec_pc_load = 1'b0; exec_pc_inc = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 16'h0000 || seq_t !== 4'd0) begin
            bad++;
            $display("FAIL reset_async: obs=%h seq_t=%0d expected obs=0000 seq_t=0", obs, seq_t);
        end
        adv(1);
        reset_n = 1'b1;
        adv(2);
        total++;
        if (obs !== 16'h0000 || seq_t !== 4'd0) begin
            bad++;
            $display("FAIL reset_idle_hold: obs=%h seq_t=%0d expected obs=0000 seq_t=0", obs, seq_t);
        end
    endtask

    task automatic test_fetch_basic();
        logic [2:0] bt [6];
        logic [9:0] got, want;
        bt = '{3'd2, 3'd7, 3'd5, 3'd0, 3'd0, 3'd0};
        start = 1'b1; ir_opcode = 3'd2; ir_i = 1'b0;
        adv(1);
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) adv(1);
            exec_done = (c == 5);
            got  = {bus_sel, pc_inc, exec_start, running, seq_t};
            want = {bt[c], (c == 1), (c == 4), 1'b1, 4'(c)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fetch_cycle%0d: {bus,pc_inc,start,run,seq}=%b expected %b", c, got, want);
            end
        end
        adv(1);
        exec_done = 1'b0;
        total++;
        if (obs !== v_f0 || seq_t !== 4'd0) begin
            bad++;
            $display("FAIL fetch_return_f0: obs=%h seq_t=%0d expected %h/0", obs, seq_t, v_f0);
        end
    endtask

    task automatic test_indirect();
        ir_opcode = 3'd1; ir_i = 1'b1;
        adv(3);
        total++;
        if (obs !== v_f3i) begin
            bad++;
            $display("FAIL f3_indirect: obs=%h expected %h", obs, v_f3i);
        end
        exec_done = 1'b1;
        adv(2);
        exec_done = 1'b0;
        ir_opcode = 3'd7; ir_i = 1'b1;
        adv(3);
        total++;
        if (obs !== v_run) begin
            bad++;
            $display("FAIL f3_regio: obs=%h expected %h", obs, v_run);
        end
        exec_done = 1'b1;
        adv(2);
        clear_inputs();
    endtask

    task automatic test_conflict();
        adv(4);
        exec_pc_load = 1'b1; exec_pc_inc = 1'b1;
        #1;
        total++;
        if ({ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr} !== 6'b000100) begin
            bad++;
            $display("FAIL pc_load_beats_inc: ar/pc=%b expected 000100",
                     {ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr});
        end
        exec_pc_load = 1'b0; exec_pc_inc = 1'b0; exec_ar_inc = 1'b1;
        #1;
        total++;
        if ({ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr} !== 6'b010000) begin
            bad++;
            $display("FAIL ar_inc_alone: ar/pc=%b expected 010000",
                     {ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr});
        end
        exec_ar_load = 1'b1;
        #1;
        total++;
        if ({ar_load, ar_inc, ar_clr} !== 3'b100) begin
            bad++;
            $display("FAIL ar_load_beats_inc: ar=%b expected 100", {ar_load, ar_inc, ar_clr});
        end
        exec_ar_load = 1'b0; exec_ar_inc = 1'b0;
        adv(1);
        exec_done = 1'b1; exec_pc_inc = 1'b1;
        #1;
        total++;
        if ({pc_load, pc_inc, pc_clr, exec_start} !== 4'b0100) begin
            bad++;
            $display("FAIL done_cycle_request: pc/start=%b expected 0100", {pc_load, pc_inc, pc_clr, exec_start});
        end
        adv(1);
        clear_inputs();
        exec_ar_inc = 1'b1; exec_pc_load = 1'b1;
        #1;
        total++;
        if (obs !== v_f0) begin
            bad++;
            $display("FAIL exec_req_outside_exec: obs=%h expected %h", obs, v_f0);
        end
        clear_inputs();
    endtask

    task automatic test_interrupt();
        logic [15:0] want [4];
        want = '{v_int0, v_int1, v_int2, v_f0};
        adv(4);
        exec_done = 1'b1; ien = 1'b1; fgi = 1'b1;
        for (int c = 0; c < 4; c++) begin
            adv(1);
            clear_inputs();
            total++;
            if (obs !== want[c] || (c == 3 && seq_t !== 4'd0)) begin
                bad++;
                $display("FAIL interrupt_cycle%0d: obs=%h seq_t=%0d expected %h", c, obs, seq_t, want[c]);
            end
        end
    endtask

    task automatic test_halt();
        adv(4);
        exec_done = 1'b1; exec_halt = 1'b1; ien = 1'b1; fgo = 1'b1;
        adv(1);
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            total++;
            if (obs !== 16'h0000) begin
                bad++;
                $display("FAIL halted_%0d: obs=%h expected 0000", c, obs);
            end
            adv(1);
        end
        start = 1'b1;
        adv(1);
        start = 1'b0;
        total++;
        if (obs !== v_f0 || seq_t !== 4'd0) begin
            bad++;
            $display("FAIL halt_restart: obs=%h seq_t=%0d expected %h/0", obs, seq_t, v_f0);
        end
    endtask

    task automatic test_reset_midway();
        adv(1);
        total++;
        if (obs !== v_f1) begin
            bad++;
            $display("FAIL pre_reset_f1: obs=%h expected %h", obs, v_f1);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 16'h0000 || seq_t !== 4'd0) begin
            bad++;
            $display("FAIL reset_midway_async: obs=%h seq_t=%0d expected 0000/0", obs, seq_t);
        end
        adv(1);
        reset_n = 1'b1;
        adv(1);
        total++;
        if (obs !== 16'h0000 || seq_t !== 4'd0) begin
            bad++;
            $display("FAIL reset_midway_idle: obs=%h seq_t=%0d expected 0000/0", obs, seq_t);
        end
    endtask

    function automatic ent_t junk();
        ent_t e;
        e.st = 1'($urandom); e.op = 3'($urandom); e.ind = 1'($urandom); e.dn = 1'($urandom);
        e.hl = 1'($urandom); e.ie = 1'($urandom); e.fi = 1'($urandom); e.fo = 1'($urandom);
        e.al = 1'($urandom); e.ai = 1'($urandom); e.pl = 1'($urandom); e.pi = 1'($urandom);
        e.v = 16'h0000; e.t = -1;
        return e;
    endfunction

    task automatic test_random();
        ent_t e;
        logic [2:0] op;
        logic ind, hl, ie, fi, fo;
        int n;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom); ind = 1'($urandom); n = $urandom_range(1, 14);
            hl = ($urandom_range(0, 7) == 0); ie = 1'($urandom); fi = 1'($urandom); fo = 1'($urandom);
            plan.delete();
            e = junk(); e.v = v_f0; e.t = 0; plan.push_back(e);
            e = junk(); e.v = v_f1; e.t = 1; plan.push_back(e);
            e = junk(); e.v = v_f2; e.t = 2; plan.push_back(e);
            e = junk(); e.op = op; e.ind = ind; e.t = 3;
            e.v = (op != 3'd7 && ind) ? v_f3i : v_run;
            plan.push_back(e);
            for (int c = 0; c < n; c++) begin
                e = junk();
                e.dn = (c == n - 1);
                if (e.dn) begin
                    e.hl = hl; e.ie = ie; e.fi = fi; e.fo = fo;
                end
                e.v = ev(e.al, e.ai & ~e.al, 1'b0, e.pl, e.pi & ~e.pl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         3'd0, 1'b0, (c == 0), 1'b1);
                e.t = (4 + c > 15) ? 15 : 4 + c;
                plan.push_back(e);
            end
            if (hl) begin
                n = $urandom_range(1, 3);
                for (int c = 0; c < n; c++) begin
                    e = junk(); e.st = (c == n - 1); e.v = 16'h0000; plan.push_back(e);
                end
            end else if (ie && (fi || fo)) begin
                e = junk(); e.v = v_int0; plan.push_back(e);
                e = junk(); e.v = v_int1; plan.push_back(e);
                e = junk(); e.v = v_int2; plan.push_back(e);
            end
            foreach (plan[j]) begin
                @(negedge clk);
                start = plan[j].st; ir_opcode = plan[j].op; ir_i = plan[j].ind;
                exec_done = plan[j].dn; exec_halt = plan[j].hl;
                ien = plan[j].ie; fgi = plan[j].fi; fgo = plan[j].fo;
                exec_ar_load = plan[j].al; exec_ar_inc = plan[j].ai;
                exec_pc_load = plan[j].pl; exec_pc_inc = plan[j].pi;
                #1;
                total++;
                if (obs !== plan[j].v || (plan[j].t >= 0 && seq_t !== plan[j].t[3:0])) begin
                    bad++;
                    $display("FAIL random_instr%0d_cycle%0d: obs=%h seq_t=%0d expected obs=%h seq_t=%0d",
                             k, j, obs, seq_t, plan[j].v, plan[j].t);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        v_f0   = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
        v_f1   = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
        v_f2   = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1);
        v_f3i  = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
        v_run  = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        v_int0 = ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
        v_int1 = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        v_int2 = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        clear_inputs();
        test_reset();
        test_fetch_basic();
        test_indirect();
        test_conflict();
        test_interrupt();
        test_halt();
        test_reset_midway();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

endmodule
